recfn_to_raw_pipe: RTL and testbench
====================================

Name: recfn_to_raw_pipe

Overview:
- Unpacks a recoded double-precision float (65-bit recFN) into raw-float fields: isNaN, isInf, isZero, sign, sExp, sig.
- Output sig and sExp widths match what the rounder consumes, so recoded values can be routed back into rounding/conversion paths.
- Implemented as a 2-stage elastic pipeline with valid/ready handshakes on both sides, so it sits between FPU register read and downstream FP units without combinational ready/valid loops.

Parameters:
- EXP_WIDTH, 11, IEEE exponent width; recoded exponent field is EXP_WIDTH+1 bits.
- SIG_WIDTH, 53, significand width including the hidden bit.
- TAG_WIDTH, 5, width of the sideband tag carried alongside each operation.

Ports:
- clock  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- io_in_valid  in  1  input operation valid.
- io_in_ready  out  1  block accepts input this cycle.
- io_in_bits  in  EXP_WIDTH+SIG_WIDTH+1 (65)  recoded float {sign, exp[11:0], fract[51:0]}.
- io_in_tag  in  TAG_WIDTH  sideband tag, returned unchanged.
- io_out_valid  out  1  output fields valid.
- io_out_ready  in  1  consumer accepts output.
- io_out_isNaN, io_out_isInf, io_out_isZero, io_out_sign, io_out_isSigNaN  out  1 each  classification bits.
- io_out_sExp  out  EXP_WIDTH+2 (13)  signed exponent, {1'b0, exp}.
- io_out_sig  out  SIG_WIDTH+3 (56)  {1'b0, ~isZero, fract, 2'b00}.
- io_out_tag  out  TAG_WIDTH  tag of the output operation.

Behaviour:
- Decode (exp = recoded exponent field):
  - isZero = exp[11:9]==0.
  - isSpecial = exp[11:10]==2'b11; isNaN = isSpecial & exp[9]; isInf = isSpecial & ~exp[9].
  - isSigNaN = isNaN & ~fract[51].
  - sign = bit 64.
  - sExp and sig are formed as stated under Ports; sig's two LSBs (round/sticky) are always 0.
- Stage 1 registers io_in_bits and tag. Stage 2 registers the decoded fields and tag. Outputs come directly from stage-2 registers.
- Latency: 2 cycles from an accepted input to io_out_valid when not stalled. Throughput: 1 op/cycle.
- Handshakes:
  - An input transfer occurs when io_in_valid & io_in_ready.
  - An output transfer occurs when io_out_valid & io_out_ready.
  - s2 advances when ~s2_valid | io_out_ready.
  - s1 advances when ~s1_valid | (s2 advances).
  - io_in_ready = ~s1_valid | (s2 advances). This is combinational from io_out_ready; there is no path from io_in_valid to io_in_ready.
- Stall: while io_out_valid & ~io_out_ready, every io_out_* field and tag holds stable. Stage 1 holds if full. No operation is dropped or duplicated.
- Bubbles collapse: an empty s2 accepts s1 even while downstream is not ready.
- Simultaneous input accept and output transfer in the same cycle are legal, and sustain full rate.
- Reset (asynchronous, any time, including mid-operation):
  - s1_valid, s2_valid, io_out_valid = 0; all data and tag registers = 0.
  - In-flight operations are discarded.
  - io_in_ready = 1 in the first cycle after reset deasserts.
- The block contains no arithmetic beyond bit selection and concatenation; every input encoding, including non-canonical NaN payloads, passes through losslessly.

Decomposition:
- Shared package fp_recfn_pkg:
  - constants EXP_WIDTH, SIG_WIDTH, RECFN_WIDTH=EXP_WIDTH+SIG_WIDTH+1;
  - raw-float struct typedef {isNaN, isInf, isZero, sign, sExp, sig};
  - field-index constants for sign, exponent and fraction.
- One natural sub-module: recfn_raw_decode, a purely combinational field decode. It is instantiated between stage 1 and stage 2 and reused by other FP units.
- The pipeline control lives in the top module.

Test Plan:
- After reset, io_in_bits=65'h0_8000_0000_0000_0000 (+1.0) with io_out_ready=1 -> 2 cycles later: io_out_valid=1, sExp=13'h0800, sig=56'h40_0000_0000_0000, all flags 0.
- io_in_bits=65'h1_0000_0000_0000_0000 (-0) -> isZero=1, sign=1, sig=0, sExp=0.
- io_in_bits=65'h0_C000_0000_0000_0000 (+Inf) -> isInf=1, isNaN=0.
- io_in_bits=65'h0_E008_0000_0000_0000 (qNaN) -> isNaN=1, isSigNaN=0.
- io_in_bits=65'h0_E000_0000_0000_0001 (sNaN) -> isNaN=1, isSigNaN=1.
- Stream of 8 back-to-back inputs, tags 0..7, with io_out_ready low for cycles 3-6:
  - io_in_ready drops once both stages are full;
  - outputs are held stable during the stall;
  - all 8 tags emerge in order, none lost or duplicated.
- Assert reset while both stages are valid -> io_out_valid=0 immediately and stays 0 until new input arrives; io_in_ready=1 after release.

Source files
------------

// File: rtl/fp_recfn_pkg.sv
// Shared recoded-float definitions: widths, field positions and the raw-float bundle
// exchanged between recFN decode logic and the rounding/conversion units.
package fp_recfn_pkg;

  localparam int EXP_WIDTH   = 11;
  localparam int SIG_WIDTH   = 53;
  localparam int RECFN_WIDTH = EXP_WIDTH + SIG_WIDTH + 1;
  localparam int TAG_WIDTH   = 5;

  // Field positions inside a recFN word {sign, exp[EXP_WIDTH:0], fract[SIG_WIDTH-2:0]}
  localparam int SIGN_IDX  = RECFN_WIDTH - 1;
  localparam int EXP_MSB   = RECFN_WIDTH - 2;
  localparam int EXP_LSB   = SIG_WIDTH - 1;
  localparam int FRACT_MSB = SIG_WIDTH - 2;
  localparam int FRACT_LSB = 0;

  typedef struct packed {
    logic                   isNaN;
    logic                   isInf;
    logic                   isZero;
    logic                   sign;
    logic [EXP_WIDTH+1:0]   sExp;
    logic [SIG_WIDTH+2:0]   sig;
  } rawFloat_t;

endpackage

// File: rtl/recfn_raw_decode.sv
// Purely combinational recFN -> raw-float field split; bit selection and concatenation only,
// so every encoding (including odd NaN payloads) passes through losslessly.
module recfn_raw_decode
  import fp_recfn_pkg::*;
(
  input  logic [RECFN_WIDTH-1:0] recFN,
  output rawFloat_t              raw,
  output logic                   isSigNaN
);

  logic [EXP_WIDTH:0]   exp;
  logic [SIG_WIDTH-2:0] fract;
  logic                 isSpecial;
  logic                 isZero;
  logic                 isNaN;

  assign exp       = recFN[EXP_MSB:EXP_LSB];
  assign fract     = recFN[FRACT_MSB:FRACT_LSB];
  assign isZero    = (exp[EXP_WIDTH -: 3] == 3'b000);
  assign isSpecial = (exp[EXP_WIDTH -: 2] == 2'b11);
  assign isNaN     = isSpecial & exp[EXP_WIDTH-2];
  // A NaN is signaling when the quiet bit (fraction MSB) is clear
  assign isSigNaN  = isNaN & ~fract[SIG_WIDTH-2];

  always_comb begin
    raw        = '0;
    raw.isNaN  = isNaN;
    raw.isInf  = isSpecial & ~exp[EXP_WIDTH-2];
    raw.isZero = isZero;
    raw.sign   = recFN[SIGN_IDX];
    raw.sExp   = {1'b0, exp};
    raw.sig    = {1'b0, ~isZero, fract, 2'b00};
  end

endmodule

// File: rtl/recfn_to_raw_pipe.sv
// Two-stage elastic pipeline unpacking a recoded double into raw-float fields.
// Stage 1 holds the raw recFN word, stage 2 holds the decoded fields that drive the outputs.
module recfn_to_raw_pipe #(
  parameter int EXP_WIDTH = fp_recfn_pkg::EXP_WIDTH,
  parameter int SIG_WIDTH = fp_recfn_pkg::SIG_WIDTH,
  parameter int TAG_WIDTH = fp_recfn_pkg::TAG_WIDTH
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           io_in_valid,
  output logic                           io_in_ready,
  input  logic [EXP_WIDTH+SIG_WIDTH:0]   io_in_bits,
  input  logic [TAG_WIDTH-1:0]           io_in_tag,
  output logic                           io_out_valid,
  input  logic                           io_out_ready,
  output logic                           io_out_isNaN,
  output logic                           io_out_isInf,
  output logic                           io_out_isZero,
  output logic                           io_out_sign,
  output logic                           io_out_isSigNaN,
  output logic [EXP_WIDTH+1:0]           io_out_sExp,
  output logic [SIG_WIDTH+2:0]           io_out_sig,
  output logic [TAG_WIDTH-1:0]           io_out_tag
);

  logic                         s1Valid;
  logic [EXP_WIDTH+SIG_WIDTH:0] s1Bits;
  logic [TAG_WIDTH-1:0]         s1Tag;

  logic                         s2Valid;
  fp_recfn_pkg::rawFloat_t      s2Raw;
  logic                         s2SigNaN;
  logic [TAG_WIDTH-1:0]         s2Tag;

  fp_recfn_pkg::rawFloat_t      decRaw;
  logic                         decSigNaN;
  logic                         s1Advance;
  logic                         s2Advance;

  // An empty stage always advances, so bubbles collapse even while downstream stalls
  assign s2Advance   = ~s2Valid | io_out_ready;
  assign s1Advance   = ~s1Valid | s2Advance;
  assign io_in_ready = s1Advance;

  recfn_raw_decode uDecode (
    .recFN    (s1Bits),
    .raw      (decRaw),
    .isSigNaN (decSigNaN)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1Valid  <= 1'b0;
      s1Bits   <= '0;
      s1Tag    <= '0;
      s2Valid  <= 1'b0;
      s2Raw    <= '0;
      s2SigNaN <= 1'b0;
      s2Tag    <= '0;
    end else begin
      if (s1Advance) begin
        s1Valid <= io_in_valid;
        if (io_in_valid) begin
          s1Bits <= io_in_bits;
          s1Tag  <= io_in_tag;
        end
      end
      if (s2Advance) begin
        s2Valid <= s1Valid;
        if (s1Valid) begin
          s2Raw    <= decRaw;
          s2SigNaN <= decSigNaN;
          s2Tag    <= s1Tag;
        end
      end
    end
  end

  assign io_out_valid    = s2Valid;
  assign io_out_isNaN    = s2Raw.isNaN;
  assign io_out_isInf    = s2Raw.isInf;
  assign io_out_isZero   = s2Raw.isZero;
  assign io_out_sign     = s2Raw.sign;
  assign io_out_isSigNaN = s2SigNaN;
  assign io_out_sExp     = s2Raw.sExp;
  assign io_out_sig      = s2Raw.sig;
  assign io_out_tag      = s2Tag;

endmodule

// File: tb/tb_recfn_to_raw_pipe.sv
// Self-checking bench for recfn_to_raw_pipe: vector table, FIFO scoreboard, stall and reset sequences.
module tb_recfn_to_raw_pipe;

  logic         clock = 1'b0;
  logic         reset;
  logic         inValid;
  logic         inReady;
  logic [64:0]  inBits;
  logic [4:0]   inTag;
  logic         outValid;
  logic         outReady;
  logic         outIsNaN, outIsInf, outIsZero, outSign, outIsSigNaN;
  logic [12:0]  outSExp;
  logic [55:0]  outSig;
  logic [4:0]   outTag;

  always #5 clock = ~clock;

  recfn_to_raw_pipe dut (
    .clock           (clock),
    .reset           (reset),
    .io_in_valid     (inValid),
    .io_in_ready     (inReady),
    .io_in_bits      (inBits),
    .io_in_tag       (inTag),
    .io_out_valid    (outValid),
    .io_out_ready    (outReady),
    .io_out_isNaN    (outIsNaN),
    .io_out_isInf    (outIsInf),
    .io_out_isZero   (outIsZero),
    .io_out_sign     (outSign),
    .io_out_isSigNaN (outIsSigNaN),
    .io_out_sExp     (outSExp),
    .io_out_sig      (outSig),
    .io_out_tag      (outTag)
  );

  typedef struct {
    logic [64:0] bits;
    logic [4:0]  flags;  // {isNaN, isInf, isZero, sign, isSigNaN}
    logic [12:0] sExp;
    logic [55:0] sig;
  } vec_t;

  typedef struct {
    logic [4:0] tag;
    int         idx;
    int         cyc;
  } sbEntry_t;

  vec_t       vecs [8];
  sbEntry_t   sb [$];
  int         passCount = 0;
  int         checkCount = 0;
  int         cycle = 0;
  int         curIdx = 0;
  bit         checkLat = 1'b0;
  bit         lastIn = 1'b0;
  bit         holdPending = 1'b0;
  logic [78:0] holdSnap;

  function automatic logic [78:0] outWord();
    return {outTag, outIsNaN, outIsInf, outIsZero, outSign, outIsSigNaN, outSExp, outSig};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checkCount++;
    if (act === req) passCount++;
    else $display("FAIL %s: got %0h, required %0h", name, act, req);
  endtask

  task automatic popCompare();
    sbEntry_t e;
    if (sb.size() == 0) begin
      check("unexpected_output", 128'(1), 128'(0));
      return;
    end
    e = sb.pop_front();
    check("tag", 128'(outTag), 128'(e.tag));
    check("flags", 128'({outIsNaN, outIsInf, outIsZero, outSign, outIsSigNaN}), 128'(vecs[e.idx].flags));
    check("sExp", 128'(outSExp), 128'(vecs[e.idx].sExp));
    check("sig", 128'(outSig), 128'(vecs[e.idx].sig));
    if (checkLat) check("latency", 128'(cycle - e.cyc), 128'(2));
    $display("out tag=%0d sExp=%0h sig=%0h flags=%b", outTag, outSExp, outSig,
             {outIsNaN, outIsInf, outIsZero, outSign, outIsSigNaN});
  endtask

  // Called at a negedge with inputs already driven; ends at the next negedge.
  task automatic step();
    #1;
    if (holdPending) begin
      check("stall_valid_held", 128'(outValid), 128'(1));
      check("stall_fields_held", 128'(outWord()), 128'(holdSnap));
    end
    lastIn = inValid && inReady;
    if (lastIn) sb.push_back('{inTag, curIdx, cycle});
    if (outValid && outReady) popCompare();
    holdPending = outValid && !outReady;
    holdSnap = outWord();
    @(posedge clock);
    cycle++;
    @(negedge clock);
  endtask

  task automatic drain(input int bound);
    int n = 0;
    inValid = 1'b0;
    outReady = 1'b1;
    while (sb.size() > 0 && n < bound) begin
      step();
      n++;
    end
    if (sb.size() > 0) check("drain_timeout", 128'(sb.size()), 128'(0));
  endtask

  initial begin
    bit sawNotReady;
    int sent;
    int n;

    vecs[0] = '{65'h0_8000_0000_0000_0000, 5'b00000, 13'h0800, 56'h40_0000_0000_0000}; // +1.0
    vecs[1] = '{65'h1_0000_0000_0000_0000, 5'b00110, 13'h0000, 56'h00_0000_0000_0000}; // -0
    vecs[2] = '{65'h0_C000_0000_0000_0000, 5'b01000, 13'h0C00, 56'h40_0000_0000_0000}; // +Inf
    vecs[3] = '{65'h0_E008_0000_0000_0000, 5'b10000, 13'h0E00, 56'h60_0000_0000_0000}; // qNaN
    vecs[4] = '{65'h0_E000_0000_0000_0001, 5'b10001, 13'h0E00, 56'h40_0000_0000_0004}; // sNaN
    vecs[5] = '{65'h1_FFFF_FFFF_FFFF_FFFF, 5'b10010, 13'h0FFF, 56'h7F_FFFF_FFFF_FFFC}; // NaN, full payload
    vecs[6] = '{65'h0_1234_5678_9ABC_DEF0, 5'b00100, 13'h0123, 56'h11_59E2_6AF3_7BC0}; // zero w/ payload
    vecs[7] = '{65'h1_BFF0_0000_0000_0000, 5'b00010, 13'h0BFF, 56'h40_0000_0000_0000}; // negative normal

    reset = 1'b1;
    inValid = 1'b0;
    inBits = '0;
    inTag = '0;
    outReady = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("reset_out_valid", 128'(outValid), 128'(0));
    check("reset_in_ready", 128'(inReady), 128'(1));
    check("reset_out_fields", 128'(outWord()), 128'(0));
    @(negedge clock);

    // Table pass at full rate with downstream always ready
    checkLat = 1'b1;
    for (int i = 0; i < 8; i++) begin
      inValid = 1'b1;
      inBits = vecs[i].bits;
      inTag = 5'(i);
      curIdx = i;
      outReady = 1'b1;
      step();
      check("full_rate_accept", 128'(lastIn), 128'(1));
    end
    drain(20);
    checkLat = 1'b0;

    // Eight back-to-back inputs with downstream stalled during cycles 3..6
    sawNotReady = 1'b0;
    sent = 0;
    n = 0;
    while ((sent < 8 || sb.size() > 0) && n < 60) begin
      inValid = (sent < 8);
      curIdx = sent % 8;
      inBits = vecs[curIdx].bits;
      inTag = 5'(sent);
      outReady = !(n >= 3 && n <= 6);
      #1;
      if (inValid && !inReady) sawNotReady = 1'b1;
      #0;
      step();
      if (lastIn) sent++;
      n++;
    end
    inValid = 1'b0;
    check("stream_in_ready_dropped", 128'(sawNotReady), 128'(1));
    check("stream_all_sent", 128'(sent), 128'(8));
    check("stream_all_emerged", 128'(sb.size()), 128'(0));

    // Reset with both stages occupied
    outReady = 1'b0;
    inValid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      curIdx = 2 + i;
      inBits = vecs[curIdx].bits;
      inTag = 5'(20 + i);
      step();
    end
    inValid = 1'b0;
    #1;
    check("pre_reset_full", 128'({outValid, inReady}), 128'(2'b10));
    #2;
    reset = 1'b1;
    #1;
    check("midreset_out_valid", 128'(outValid), 128'(0));
    check("midreset_fields", 128'(outWord()), 128'(0));
    sb.delete();
    holdPending = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    outReady = 1'b1;
    #1;
    check("post_reset_in_ready", 128'(inReady), 128'(1));
    @(negedge clock);
    for (int i = 0; i < 3; i++) begin
      step();
      check("post_reset_idle", 128'(outValid), 128'(0));
    end

    // Pipeline still works after the mid-flight reset
    checkLat = 1'b1;
    inValid = 1'b1;
    curIdx = 4;
    inBits = vecs[4].bits;
    inTag = 5'd9;
    step();
    drain(10);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
